// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between MEM/WB writeback and a long-latency unit
//
// Purpose:
//   The register file has a single write port. The in-order MEM/WB writeback (WB)
//   always wins it when it has an effective write. Long-latency unit (LU) results
//   are buffered in a small FIFO and drained whenever WB leaves the port free.
//   If WB keeps winning while the FIFO holds entries, a starvation counter forces
//   a one-cycle stall of the MEM/WB register so the FIFO head can be written.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous, active-low; clears all state
//   wb_regWrite    WB write request (effective only when wb_rd != 0)
//   wb_rd          WB destination register
//   wb_data        WB write data
//   lu_valid       LU result valid
//   lu_rd          LU destination register (0 = accepted and dropped)
//   lu_data        LU result data
//   lu_ready       FIFO can accept a result (= !full, combinational)
//   rf_write       register-file write enable (registered)
//   rf_write_reg   register-file write address (registered, holds when idle)
//   rf_write_data  register-file write data (registered, holds when idle)
//   stall          freeze the MEM/WB register this cycle (FORCE state)
//   fifo_count     number of buffered LU results

module wb_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 wb_regWrite,
    input  logic [4:0]                           wb_rd,
    input  logic [DATA_WIDTH-1:0]                wb_data,
    input  logic                                 lu_valid,
    input  logic [4:0]                           lu_rd,
    input  logic [DATA_WIDTH-1:0]                lu_data,
    output logic                                 lu_ready,
    output logic                                 rf_write,
    output logic [4:0]                           rf_write_reg,
    output logic [DATA_WIDTH-1:0]                rf_write_data,
    output logic                                 stall,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FORCE = 2'd2;

    logic [1:0]            state, state_nxt;
    logic [SW-1:0]         starve, starve_nxt;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;

    logic [4:0]            mem_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];

    logic                  full;
    logic                  wb_eff;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  sel_wb;
    logic                  sel_lu;
    logic                  last_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign lu_ready   = !full;
    assign wb_eff     = wb_regWrite && (wb_rd != 5'd0);
    assign accept     = lu_valid && lu_ready;
    // A result for x0 is consumed from the LU but never occupies a slot.
    assign push       = accept && (lu_rd != 5'd0);
    // The pop about to happen empties the FIFO unless a push refills it.
    assign last_entry = (count == CNT_W'(1)) && !push;
    assign stall      = (state == ST_FORCE);
    assign fifo_count = count;

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve;
        pop        = 1'b0;
        sel_wb     = 1'b0;
        sel_lu     = 1'b0;
        case (state)
            ST_IDLE: begin
                sel_wb     = wb_eff;
                starve_nxt = '0;
                if (push) begin
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (wb_eff) begin
                    sel_wb     = 1'b1;
                    starve_nxt = starve + 1'b1;
                    if (starve_nxt == SW'(STARVE_LIMIT)) begin
                        state_nxt = ST_FORCE;
                    end
                end else begin
                    pop        = 1'b1;
                    sel_lu     = 1'b1;
                    starve_nxt = '0;
                    if (last_entry) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_FORCE: begin
                // WB is frozen this cycle and will re-present its write next cycle.
                pop        = 1'b1;
                sel_lu     = 1'b1;
                starve_nxt = '0;
                state_nxt  = last_entry ? ST_IDLE : ST_PEND;
            end
            default: begin
                state_nxt  = ST_IDLE;
                starve_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            starve <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_nxt;
            starve <= starve_nxt;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define which slots are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_rd[wr_ptr]   <= lu_rd;
            mem_data[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_write      <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else if (sel_wb) begin
            rf_write      <= 1'b1;
            rf_write_reg  <= wb_rd;
            rf_write_data <= wb_data;
        end else if (sel_lu) begin
            rf_write      <= 1'b1;
            rf_write_reg  <= mem_rd[rd_ptr];
            rf_write_data <= mem_data[rd_ptr];
        end else begin
            rf_write      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized self-checking bench for wb_port_arbiter

module tb_wb_port_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          wb_regWrite;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          lu_valid;
    logic [4:0]    lu_rd;
    logic [DW-1:0] lu_data;
    logic          lu_ready;
    logic          rf_write;
    logic [4:0]    rf_write_reg;
    logic [DW-1:0] rf_write_data;
    logic          stall;
    logic [CW-1:0] fifo_count;

    wb_port_arbiter #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wb_regWrite  (wb_regWrite),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .lu_valid     (lu_valid),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .rf_write     (rf_write),
        .rf_write_reg (rf_write_reg),
        .rf_write_data(rf_write_data),
        .stall        (stall),
        .fifo_count   (fifo_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of pending LU results, the number of consecutive
    // WB wins while results wait, and whether the next cycle is a forced drain.
    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          m_q[$];
    int            m_wins;
    bit            m_force;
    logic          m_we;
    logic [4:0]    m_reg;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        m_q.delete();
        m_wins  = 0;
        m_force = 0;
        m_we    = 0;
        m_reg   = '0;
        m_data  = '0;
    endtask

    task automatic model_step();
        bit   eff;
        bit   acc;
        ent_t e;
        eff  = wb_regWrite && (wb_rd != 0);
        acc  = lu_valid && (m_q.size() < DEPTH);
        m_we = 0;
        if (m_force) begin
            e = m_q.pop_front();
            m_we = 1; m_reg = e.rd; m_data = e.data;
            m_force = 0;
            m_wins  = 0;
        end else if (m_q.size() == 0) begin
            if (eff) begin
                m_we = 1; m_reg = wb_rd; m_data = wb_data;
            end
            m_wins = 0;
        end else if (eff) begin
            m_we = 1; m_reg = wb_rd; m_data = wb_data;
            m_wins++;
            if (m_wins == LIMIT) m_force = 1;
        end else begin
            e = m_q.pop_front();
            m_we = 1; m_reg = e.rd; m_data = e.data;
            m_wins = 0;
        end
        if (acc && lu_rd != 0) begin
            e.rd = lu_rd; e.data = lu_data;
            m_q.push_back(e);
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        #1;
        check("lu_ready", lu_ready, m_q.size() < DEPTH);
        check("stall", stall, m_force);
        model_step();
        @(posedge clock);
        #1;
        check("rf_write", rf_write, m_we);
        check("rf_write_reg", rf_write_reg, m_reg);
        check("rf_write_data", rf_write_data, m_data);
        check("fifo_count", fifo_count, m_q.size());
    endtask

    task automatic drive(input logic we, input logic [4:0] wrd, input logic [DW-1:0] wd,
                         input logic lv, input logic [4:0] lrd, input logic [DW-1:0] ld);
        wb_regWrite = we; wb_rd = wrd; wb_data = wd;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic random_phase(input int n, input int wb_pct, input int lu_pct);
        for (int i = 0; i < n; i++) begin
            wb_regWrite = ($urandom_range(99) < wb_pct);
            wb_rd       = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            wb_data     = $urandom;
            lu_valid    = ($urandom_range(99) < lu_pct);
            lu_rd       = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            lu_data     = $urandom;
            cycle();
        end
    endtask

    initial begin
        reset = 1'b0;
        wb_regWrite = 0; wb_rd = 0; wb_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_rf_write", rf_write, 0);
        check("reset_rf_write_reg", rf_write_reg, 0);
        check("reset_rf_write_data", rf_write_data, 0);
        check("reset_stall", stall, 0);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_lu_ready", lu_ready, 1);
        @(negedge clock);
        reset = 1'b1;

        // WB only write
        drive(1, 5, 32'hA5, 0, 0, 0);
        check("wb_only_reg", rf_write_reg, 5);
        idle(1);
        // LU with WB idle: written two cycles after accept
        drive(0, 0, 0, 1, 7, 32'h1234);
        check("lu_count_after_accept", fifo_count, 1);
        idle(1);
        check("lu_written_reg", rf_write_reg, 7);
        idle(1);
        // Starvation: fill FIFO, keep WB effective
        drive(1, 1, 32'h11, 1, 9, 32'h900);
        drive(1, 2, 32'h22, 1, 10, 32'hA00);
        for (int i = 0; i < 14; i++) drive(1, 5'(3 + i), 32'(i), 1, 11, 32'hB00 + 32'(i));
        idle(4);
        // rd==0 filtering
        drive(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        check("rd0_fifo_count", fifo_count, 0);
        check("rd0_rf_write", rf_write, 0);
        // Push+pop at count 1 in PEND with WB idle
        drive(1, 4, 32'h44, 1, 12, 32'hC00);
        drive(0, 0, 0, 1, 13, 32'hD00);
        drive(0, 0, 0, 0, 0, 0);
        idle(3);
        // Reset in the middle of a forced drain
        drive(1, 1, 32'h1, 1, 14, 32'hE00);
        drive(1, 2, 32'h2, 1, 15, 32'hF00);
        drive(1, 3, 32'h3, 0, 0, 0);
        drive(1, 4, 32'h4, 0, 0, 0);
        drive(1, 5, 32'h5, 0, 0, 0);
        @(negedge clock);
        #1;
        check("pre_reset_stall", stall, m_force);
        check("pre_reset_count", fifo_count, m_q.size());
        reset = 1'b0;
        #1;
        check("async_reset_stall", stall, 0);
        check("async_reset_rf_write", rf_write, 0);
        check("async_reset_fifo_count", fifo_count, 0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        check("post_reset_stall", stall, 0);

        random_phase(600, 50, 50);
        random_phase(600, 90, 70);
        random_phase(600, 20, 80);
        random_phase(400, 100, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
